// File: rtl/multiport_memory_interface_if.sv
// Bundles the cache-side and memory-side buses of multiport_memory_interface.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding caches and memory that drive requests and word responses.
interface multiport_memory_interface_if #(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NUM_PORTS     = 2
);
    localparam int BW = DATA_WIDTH * (1 << OFFSET_BITS);

    logic [NUM_PORTS*MSG_BITS-1:0]      cache2interface_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2interface_address;
    logic [NUM_PORTS*BW-1:0]            cache2interface_data;
    logic [NUM_PORTS*MSG_BITS-1:0]      interface2cache_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] interface2cache_address;
    logic [NUM_PORTS*BW-1:0]            interface2cache_data;
    logic [MSG_BITS-1:0]                mem2interface_msg;
    logic [DATA_WIDTH-1:0]              mem2interface_data;
    logic [MSG_BITS-1:0]                interface2mem_msg;
    logic [ADDRESS_WIDTH-1:0]           interface2mem_address;
    logic [DATA_WIDTH-1:0]              interface2mem_data;

    modport master (
        output cache2interface_msg, cache2interface_address, cache2interface_data,
        output mem2interface_msg, mem2interface_data,
        input  interface2cache_msg, interface2cache_address, interface2cache_data,
        input  interface2mem_msg, interface2mem_address, interface2mem_data
    );

    modport slave (
        input  cache2interface_msg, cache2interface_address, cache2interface_data,
        input  mem2interface_msg, mem2interface_data,
        output interface2cache_msg, interface2cache_address, interface2cache_data,
        output interface2mem_msg, interface2mem_address, interface2mem_data
    );
endinterface

// File: rtl/multiport_memory_interface.sv
// Multiport memory interface: arbitrates line requests from NUM_PORTS caches
// and serialises each line into word requests to a single word-wide memory.
// Optional macro MEM_RR_ARB_EN selects round-robin arbitration; without it the
// lowest-numbered requesting port always wins.
module multiport_memory_interface #(
    parameter int OFFSET_BITS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4,
    parameter int NUM_PORTS     = 2
) (
    input  logic clock,
    input  logic reset,
    multiport_memory_interface_if.slave bus
);
    localparam int WPL = 1 << OFFSET_BITS;
    localparam int BW  = DATA_WIDTH * WPL;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW  = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;

    // Message codes shared with the caches and memory.
    localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FLUSH    = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(11);

    localparam logic [ADDRESS_WIDTH-1:0] BASE_MASK = {ADDRESS_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [CW-1:0]            LAST_WORD = CW'(WPL - 1);

    typedef enum logic [1:0] {IDLE, READ_MEMORY, WRITE_MEMORY, RESPOND} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            portIdx_q, portIdx_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic                     isWrite_q, isWrite_d;
    logic [CW-1:0]            count_q, count_d;
    logic [BW-1:0]            writeLine_q, writeLine_d;
    logic [BW-1:0]            readLine_q, readLine_d;
    logic [MSG_BITS-1:0]      memMsg_q, memMsg_d;
    logic [ADDRESS_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0]    memData_q, memData_d;
`ifdef MEM_RR_ARB_EN
    logic [PW-1:0]            lastGrant_q, lastGrant_d;
`endif

    logic [NUM_PORTS-1:0]     reqVec;
    logic                     grantValid;
    logic [PW-1:0]            grantIdx;
    logic [MSG_BITS-1:0]      reqMsg;
    logic [ADDRESS_WIDTH-1:0] lineBase;
    logic [CW-1:0]            nextCount;

    // Flag every port presenting a code that starts a memory transaction.
    always_comb begin
        reqVec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            reqVec[p] = (bus.cache2interface_msg[p*MSG_BITS +: MSG_BITS] == R_REQ)  ||
                        (bus.cache2interface_msg[p*MSG_BITS +: MSG_BITS] == WB_REQ) ||
                        (bus.cache2interface_msg[p*MSG_BITS +: MSG_BITS] == FLUSH);
        end
    end

    // Pick the port to serve next; only consulted while IDLE.
`ifdef MEM_RR_ARB_EN
    always_comb begin
        int cand;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(lastGrant_q) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!grantValid && reqVec[PW'(cand)]) begin
                grantValid = 1'b1;
                grantIdx   = PW'(cand);
            end
        end
    end
`else
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (reqVec[p]) begin
                grantValid = 1'b1;
                grantIdx   = PW'(p);
            end
        end
    end
`endif

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            portIdx_q   <= '0;
            base_q      <= '0;
            isWrite_q   <= 1'b0;
            count_q     <= '0;
            writeLine_q <= '0;
            readLine_q  <= '0;
            memMsg_q    <= NO_REQ;
            memAddr_q   <= '0;
            memData_q   <= '0;
`ifdef MEM_RR_ARB_EN
            lastGrant_q <= PW'(NUM_PORTS - 1);
`endif
        end else begin
            state_q     <= state_d;
            portIdx_q   <= portIdx_d;
            base_q      <= base_d;
            isWrite_q   <= isWrite_d;
            count_q     <= count_d;
            writeLine_q <= writeLine_d;
            readLine_q  <= readLine_d;
            memMsg_q    <= memMsg_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
`ifdef MEM_RR_ARB_EN
            lastGrant_q <= lastGrant_d;
`endif
        end
    end

    // Next-state logic: accept a line, walk its words through memory, respond.
    always_comb begin
        state_d     = state_q;
        portIdx_d   = portIdx_q;
        base_d      = base_q;
        isWrite_d   = isWrite_q;
        count_d     = count_q;
        writeLine_d = writeLine_q;
        readLine_d  = readLine_q;
        memMsg_d    = memMsg_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
`ifdef MEM_RR_ARB_EN
        lastGrant_d = lastGrant_q;
`endif
        reqMsg      = bus.cache2interface_msg[grantIdx*MSG_BITS +: MSG_BITS];
        lineBase    = bus.cache2interface_address[grantIdx*ADDRESS_WIDTH +: ADDRESS_WIDTH] & BASE_MASK;
        nextCount   = count_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    portIdx_d   = grantIdx;
                    base_d      = lineBase;
                    count_d     = '0;
                    writeLine_d = bus.cache2interface_data[grantIdx*BW +: BW];
                    memAddr_d   = lineBase;
`ifdef MEM_RR_ARB_EN
                    lastGrant_d = grantIdx;
`endif
                    if (reqMsg == R_REQ) begin
                        state_d   = READ_MEMORY;
                        isWrite_d = 1'b0;
                        memMsg_d  = R_REQ;
                        memData_d = '0;
                    end else begin
                        state_d   = WRITE_MEMORY;
                        isWrite_d = 1'b1;
                        memMsg_d  = WB_REQ;
                        memData_d = writeLine_d[DATA_WIDTH-1:0];
                    end
                end
            end
            READ_MEMORY, WRITE_MEMORY: begin
                if (bus.mem2interface_msg == MEM_RESP) begin
                    if (state_q == READ_MEMORY) begin
                        readLine_d[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] = bus.mem2interface_data;
                    end
                    if (count_q == LAST_WORD) begin
                        state_d   = RESPOND;
                        count_d   = '0;
                        memMsg_d  = NO_REQ;
                        memAddr_d = '0;
                        memData_d = '0;
                    end else begin
                        count_d   = nextCount;
                        memAddr_d = memAddr_q + ADDRESS_WIDTH'(1);
                        if (state_q == WRITE_MEMORY) begin
                            memData_d = writeLine_q[int'(nextCount)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the granted port ever sees a response, and only during RESPOND.
    always_comb begin
        bus.interface2cache_msg     = '0;
        bus.interface2cache_address = '0;
        bus.interface2cache_data    = '0;
        if (state_q == RESPOND) begin
            bus.interface2cache_msg[portIdx_q*MSG_BITS +: MSG_BITS]               = MEM_RESP;
            bus.interface2cache_address[portIdx_q*ADDRESS_WIDTH +: ADDRESS_WIDTH] = base_q;
            bus.interface2cache_data[portIdx_q*BW +: BW] = isWrite_q ? '0 : readLine_q;
        end
    end

    assign bus.interface2mem_msg     = memMsg_q;
    assign bus.interface2mem_address = memAddr_q;
    assign bus.interface2mem_data    = memData_q;
endmodule

// File: tb/tb_multiport_memory_interface.sv
// Self-checking bench for multiport_memory_interface: table-driven line
// transactions plus hand-written stall, reset-abort and arbitration sequences.
module tb_multiport_memory_interface;
    localparam int OFFSET_BITS   = 2;
    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int MSG_BITS      = 4;
    localparam int NUM_PORTS     = 2;
    localparam int WPL           = 4;
    localparam int BW            = 128;

    localparam logic [3:0] NO_REQ   = 4'd0;
    localparam logic [3:0] WB_REQ   = 4'd1;
    localparam logic [3:0] R_REQ    = 4'd2;
    localparam logic [3:0] FLUSH    = 4'd3;
    localparam logic [3:0] MEM_RESP = 4'd11;

    typedef struct {
        int           port;
        logic [3:0]   msg;
        logic [31:0]  addr;
        logic [127:0] line;
        logic [31:0]  salt;
        logic [31:0]  expBase;
        logic [127:0] expLine;
    } vec_t;

    typedef struct {
        logic [3:0]  msg;
        logic [31:0] addr;
        logic [31:0] data;
    } memEntry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] salt = 32'd0;
    logic        stallEn = 1'b0;
    int          stallCnt = 0;
    logic        memRespNow;
    int          checkCount = 0;
    int          passCount = 0;
    memEntry_t   memLog[$];
    vec_t        vecs[5];

    multiport_memory_interface_if #(
        .OFFSET_BITS(OFFSET_BITS), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .MSG_BITS(MSG_BITS), .NUM_PORTS(NUM_PORTS)
    ) bus ();

    multiport_memory_interface #(
        .OFFSET_BITS(OFFSET_BITS), .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .MSG_BITS(MSG_BITS), .NUM_PORTS(NUM_PORTS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memWord(input logic [31:0] a, input logic [31:0] s);
        return 32'hA0 + {30'd0, a[1:0]} + s;
    endfunction

    // Single-cycle memory model, optionally holding off word 2 for three cycles.
    always_comb begin
        memRespNow = 1'b0;
        if (bus.interface2mem_msg != NO_REQ) begin
            memRespNow = !(stallEn && bus.interface2mem_address[1:0] == 2'd2 && stallCnt < 3);
        end
        bus.mem2interface_msg  = memRespNow ? MEM_RESP : NO_REQ;
        bus.mem2interface_data = (memRespNow && bus.interface2mem_msg == R_REQ)
                                 ? memWord(bus.interface2mem_address, salt) : 32'd0;
    end

    // Count stalled cycles and record every completed memory word.
    always @(posedge clock) begin
        if (stallEn && bus.interface2mem_msg != NO_REQ &&
            bus.interface2mem_address[1:0] == 2'd2 && !memRespNow) begin
            stallCnt <= stallCnt + 1;
        end else begin
            stallCnt <= 0;
        end
        if (bus.interface2mem_msg != NO_REQ && memRespNow) begin
            memLog.push_back('{bus.interface2mem_msg, bus.interface2mem_address, bus.interface2mem_data});
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setReq(input int port, input logic [3:0] msg, input logic [31:0] addr,
                          input logic [127:0] line);
        bus.cache2interface_msg[port*MSG_BITS +: MSG_BITS]               = msg;
        bus.cache2interface_address[port*ADDRESS_WIDTH +: ADDRESS_WIDTH] = addr;
        bus.cache2interface_data[port*BW +: BW]                          = line;
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "_cacheMsg"},  {120'd0, bus.interface2cache_msg}, 128'd0);
        checkOutput({tag, "_cacheAddr"}, {64'd0, bus.interface2cache_address}, 128'd0);
        checkOutput({tag, "_cacheData"}, (bus.interface2cache_data == '0) ? 128'd0 : 128'd1, 128'd0);
        checkOutput({tag, "_memMsg"},    {124'd0, bus.interface2mem_msg}, 128'd0);
        checkOutput({tag, "_memAddr"},   {96'd0, bus.interface2mem_address}, 128'd0);
        checkOutput({tag, "_memData"},   {96'd0, bus.interface2mem_data}, 128'd0);
    endtask

    // One full line transaction from an idle interface, checked end to end.
    task automatic applyStimulus(input vec_t v);
        int         cycles;
        bit         got;
        int         other;
        logic [3:0] expMsg;
        other  = 1 - v.port;
        expMsg = (v.msg == R_REQ) ? R_REQ : WB_REQ;
        memLog.delete();
        salt = v.salt;
        setReq(v.port, v.msg, v.addr, v.line);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (bus.interface2cache_msg[v.port*MSG_BITS +: MSG_BITS] == MEM_RESP) got = 1'b1;
        end
        checkOutput("latency", cycles, 5);
        if (got) begin
            checkOutput("respAddr", bus.interface2cache_address[v.port*ADDRESS_WIDTH +: ADDRESS_WIDTH], v.expBase);
            checkOutput("respLine", bus.interface2cache_data[v.port*BW +: BW], v.expLine);
            checkOutput("otherPortMsg", bus.interface2cache_msg[other*MSG_BITS +: MSG_BITS], NO_REQ);
            checkOutput("otherPortData", bus.interface2cache_data[other*BW +: BW], 128'd0);
            checkOutput("memIdleInRespond", bus.interface2mem_msg, NO_REQ);
        end
        setReq(v.port, NO_REQ, 32'd0, 128'd0);
        checkOutput("memWordCount", memLog.size(), WPL);
        for (int k = 0; k < memLog.size() && k < WPL; k++) begin
            checkOutput("memMsg", memLog[k].msg, expMsg);
            checkOutput("memAddr", memLog[k].addr, v.expBase + k);
            checkOutput("memData", memLog[k].data,
                        (v.msg == R_REQ) ? 32'd0 : v.line[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        @(negedge clock);
        checkOutput("respOneCycle", bus.interface2cache_msg[v.port*MSG_BITS +: MSG_BITS], NO_REQ);
    endtask

    initial begin
        int  cycles;
        int  word2Cycles;
        bit  got;
        bit  sawResp;
        int  grantPort;
        int  expGrant[4];
        vec_t v;

        bus.cache2interface_msg     = '0;
        bus.cache2interface_address = '0;
        bus.cache2interface_data    = '0;

`ifdef MEM_RR_ARB_EN
        expGrant = '{0, 1, 0, 1};
`else
        expGrant = '{0, 0, 0, 0};
`endif

        vecs[0] = '{0, R_REQ, 32'h0000_0103, 128'd0, 32'd0, 32'h0000_0100,
                    128'h000000A3_000000A2_000000A1_000000A0};
        vecs[1] = '{1, FLUSH, 32'h0000_0200, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0,
                    32'd0, 32'h0000_0200, 128'd0};
        vecs[2] = '{1, R_REQ, 32'hFFFF_FFFE, 128'd0, 32'd0, 32'hFFFF_FFFC,
                    128'h000000A3_000000A2_000000A1_000000A0};
        vecs[3] = '{0, WB_REQ, 32'h0000_0007, 128'h33333333_22222222_11111111_00000000,
                    32'd0, 32'h0000_0004, 128'd0};
        vecs[4] = '{1, R_REQ, 32'h0000_0542, 128'd0, 32'h0000_5500, 32'h0000_0540,
                    128'h000055A3_000055A2_000055A1_000055A0};

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkAllIdle("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Codes outside R_REQ/WB_REQ/FLUSH must not start a transfer.
        setReq(0, MEM_RESP, 32'h0000_0800, 128'd0);
        setReq(1, 4'd7, 32'h0000_0900, 128'd0);
        repeat (3) begin
            @(negedge clock);
            checkOutput("ignoredCode", bus.interface2mem_msg, NO_REQ);
        end
        setReq(0, NO_REQ, 32'd0, 128'd0);
        setReq(1, NO_REQ, 32'd0, 128'd0);
        @(negedge clock);

        // Memory stalls three cycles on word 2.
        stallEn = 1'b1;
        salt    = 32'd0;
        memLog.delete();
        setReq(0, R_REQ, 32'h0000_0300, 128'd0);
        cycles = 0;
        word2Cycles = 0;
        got = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (bus.interface2mem_msg == R_REQ && bus.interface2mem_address == 32'h0000_0302 &&
                bus.interface2mem_data == 32'd0) word2Cycles++;
            if (bus.interface2cache_msg[0 +: MSG_BITS] == MEM_RESP) got = 1'b1;
        end
        setReq(0, NO_REQ, 32'd0, 128'd0);
        stallEn = 1'b0;
        checkOutput("stallLatency", cycles, 8);
        checkOutput("stallWord2Held", word2Cycles, 4);
        checkOutput("stallLine", bus.interface2cache_data[0 +: BW],
                    128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clock);

        // Reset after word 1 of a read aborts the transfer silently.
        memLog.delete();
        sawResp = 1'b0;
        setReq(0, R_REQ, 32'h0000_0400, 128'd0);
        cycles = 0;
        while (memLog.size() < 2 && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (bus.interface2cache_msg != '0) sawResp = 1'b1;
        end
        checkOutput("abortReachedWord2", bus.interface2mem_address, 32'h0000_0402);
        reset = 1'b1;
        setReq(0, NO_REQ, 32'd0, 128'd0);
        @(negedge clock);
        if (bus.interface2cache_msg != '0) sawResp = 1'b1;
        checkAllIdle("abort");
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (bus.interface2cache_msg != '0) sawResp = 1'b1;
        end
        checkOutput("abortNoResp", sawResp, 1'b0);
        v = '{0, R_REQ, 32'h0000_0401, 128'd0, 32'd0, 32'h0000_0400,
              128'h000000A3_000000A2_000000A1_000000A0};
        applyStimulus(v);

        // Both ports request continuously from a fresh reset.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        setReq(0, R_REQ, 32'h0000_0600, 128'd0);
        setReq(1, R_REQ, 32'h0000_0700, 128'd0);
        for (int g = 0; g < 4; g++) begin
            cycles = 0;
            grantPort = -1;
            while (grantPort < 0 && cycles < 40) begin
                @(negedge clock);
                cycles++;
                if (bus.interface2cache_msg[0 +: MSG_BITS] == MEM_RESP) grantPort = 0;
                else if (bus.interface2cache_msg[MSG_BITS +: MSG_BITS] == MEM_RESP) grantPort = 1;
            end
            checkOutput("arbGrant", grantPort, expGrant[g]);
        end
        setReq(0, NO_REQ, 32'd0, 128'd0);
        setReq(1, NO_REQ, 32'd0, 128'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/multiport_memory_interface.md
MULTIPORT_MEMORY_INTERFACE -- requirements
Module: multiport_memory_interface

Interface
REQ-001 SHALL have parameter OFFSET_BITS, default 2: log2 of words per line (WPL = 1<<OFFSET_BITS).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: memory word width; line bus BW = DATA_WIDTH*WPL.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32: word address width.
REQ-004 SHALL have parameter MSG_BITS, default 4: message code width; codes NO_REQ, R_REQ, WB_REQ, FLUSH, MEM_RESP from the shared params.h.
REQ-005 SHALL have parameter NUM_PORTS, default 2: number of cache ports, range 1..16.
REQ-006 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port cache2interface_msg  in  NUM_PORTS*MSG_BITS  per-port request code; port p at slice [p*MSG_BITS +: MSG_BITS].
REQ-009 SHALL have port cache2interface_address  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address.
REQ-010 SHALL have port cache2interface_data  in  NUM_PORTS*BW  per-port write line; word k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port interface2cache_msg  out  NUM_PORTS*MSG_BITS  per-port response code.
REQ-012 SHALL have port interface2cache_address  out  NUM_PORTS*ADDRESS_WIDTH  per-port response line base address.
REQ-013 SHALL have port interface2cache_data  out  NUM_PORTS*BW  per-port read line.
REQ-014 SHALL have port mem2interface_msg  in  MSG_BITS  memory response code (MEM_RESP = word done).
REQ-015 SHALL have port mem2interface_data  in  DATA_WIDTH  memory read word.
REQ-016 SHALL have ports interface2mem_msg / interface2mem_address / interface2mem_data  out  MSG_BITS / ADDRESS_WIDTH / DATA_WIDTH  registered word request to memory.

Function
REQ-017 SHALL implement states IDLE, READ_MEMORY, WRITE_MEMORY, RESPOND.
REQ-018 IDLE: port p requests if msg in {R_REQ, WB_REQ, FLUSH}; other codes ignored; with no requester stay IDLE.
REQ-019 IDLE accept: latch granted port index, line base = address with low OFFSET_BITS cleared, full write line; word counter = 0.
REQ-020 R_REQ accept -> READ_MEMORY, interface2mem_msg=R_REQ, address=base.
REQ-021 WB_REQ or FLUSH accept -> WRITE_MEMORY, interface2mem_msg=WB_REQ, address=base, data=latched word 0.
REQ-022 Per word: hold interface2mem_* stable until mem2interface_msg==MEM_RESP; on MEM_RESP with counter<WPL-1: (read) store mem2interface_data in slot counter, counter+1, address+1, (write) data=next latched word.
REQ-023 MEM_RESP on word WPL-1: store final read word, drive interface2mem_* to NO_REQ/0/0, -> RESPOND.
REQ-024 RESPOND lasts exactly one cycle: granted port sees msg=MEM_RESP, address=base, data=assembled line (write: data=0); -> IDLE.
REQ-025 Non-granted ports SHALL see NO_REQ, address 0, data 0 at all times; granted port same outside RESPOND.
REQ-026 Requester SHALL hold its request until MEM_RESP; the cycle after RESPOND is IDLE and rearbitrates.
REQ-027 Requests arriving while busy wait; no queueing beyond the held request.
REQ-028 Latency: R_REQ accepted cycle 0 -> MEM_RESP to cache no earlier than cycle WPL+1 with single-cycle memory.
REQ-029 Word address increment wraps modulo 2^ADDRESS_WIDTH.

Reset
REQ-030 Reset SHALL force IDLE, all interface2cache_* and interface2mem_* outputs NO_REQ/0, counter 0, read buffer 0, last-grant pointer NUM_PORTS-1.
REQ-031 Reset mid-transfer SHALL abort with no MEM_RESP to any port; outputs idle at the following edge.

Configuration
REQ-032 Macro MEM_RR_ARB_EN defined: round-robin grant, first requester after last-granted port, wrapping; pointer updated on accept.
REQ-033 MEM_RR_ARB_EN undefined: fixed priority, lowest requesting port index wins; pointer unused.

Verification
REQ-034 Port0 R_REQ addr 0x103, memory returns 0xA0..0xA3 one per cycle -> mem addrs 0x100..0x103, port0 MEM_RESP addr 0x100 line {A3,A2,A1,A0} at cycle 5.
REQ-035 Port1 FLUSH addr 0x200 line {D3..D0} -> four WB_REQ at 0x200..0x203 data D0..D3, one-cycle MEM_RESP on port1 only.
REQ-036 Ports 0,1 both R_REQ continuously, RR on -> grants 0,1,0,1; RR off -> port0 each time it requests.
REQ-037 Memory stalls 3 cycles on word 2 -> interface2mem_* stable throughout, completion delayed 3 cycles.
REQ-038 Reset asserted after word 1 of read -> no MEM_RESP, all outputs 0/NO_REQ next edge, next request starts from word 0.
